// File: rtl/knapsack_dp_seq.sv
// Knapsack DP sequencer: clears the cache, sweeps every item over capacities cap..0, then reads cache[cap].
// done is seen cap+4+item_num*(cap+4) edges after start is accepted; one cache read-modify-write per cycle.
module knapsack_dp_seq #(
  parameter int MAX_CAP  = 64,
  parameter int MAX_ITEM = 16,
  parameter int DW       = 32
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic [$clog2(MAX_ITEM):0]   item_num,
  input  logic [$clog2(MAX_CAP)-1:0]  cap,
  output logic [$clog2(MAX_ITEM)-1:0] item_addr,
  input  logic [DW-1:0]               item_weight,
  input  logic [DW-1:0]               item_value,
  output logic [$clog2(MAX_CAP)-1:0]  rd_addr_a,
  output logic [$clog2(MAX_CAP)-1:0]  rd_addr_b,
  input  logic [DW-1:0]               rd_data_a,
  input  logic [DW-1:0]               rd_data_b,
  output logic                        wr_en,
  output logic [$clog2(MAX_CAP)-1:0]  wr_addr,
  output logic [DW-1:0]               wr_data,
  output logic                        busy,
  output logic                        done,
  output logic                        error,
  output logic [DW-1:0]               result
);

  localparam int CW = $clog2(MAX_CAP);
  localparam int IW = $clog2(MAX_ITEM);
  localparam int NW = IW + 1;

  typedef enum logic [3:0] {
    S_IDLE, S_CLEAR, S_FETCH, S_WAIT, S_SCAN, S_DRAIN, S_RESULT, S_CAPTURE, S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [NW-1:0]   num_q, num_d, i_q, i_d;
  logic [CW-1:0]   cap_q, cap_d, c_q, c_d, wr_c_q, wr_c_d;
  logic [DW-1:0]   w_q, w_d, v_q, v_d, result_q, result_d;
  logic            wr_pend_q, wr_pend_d, error_q, error_d;

  logic            args_ok, fits;
  logic [DW:0]     sum;
  logic [DW-1:0]   sat_sum, best;
  logic [NW-1:0]   i_nxt;

  assign args_ok = (item_num <= NW'(MAX_ITEM)) && ({1'b0, cap} <= (CW+1)'(MAX_CAP - 1));
  // Full-width compare so weights beyond the address range never alias onto a small one.
  assign fits    = ({{(DW-CW){1'b0}}, c_q} >= w_q);
  assign sum     = {1'b0, rd_data_b} + {1'b0, v_q};
  assign sat_sum = sum[DW] ? '1 : sum[DW-1:0];
  assign best    = (rd_data_a > sat_sum) ? rd_data_a : sat_sum;
  assign i_nxt   = i_q + NW'(1);

  assign busy   = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done   = (state_q == S_DONE);
  assign error  = error_q;
  assign result = result_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      num_q     <= '0;
      i_q       <= '0;
      cap_q     <= '0;
      c_q       <= '0;
      wr_c_q    <= '0;
      w_q       <= '0;
      v_q       <= '0;
      result_q  <= '0;
      wr_pend_q <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      num_q     <= num_d;
      i_q       <= i_d;
      cap_q     <= cap_d;
      c_q       <= c_d;
      wr_c_q    <= wr_c_d;
      w_q       <= w_d;
      v_q       <= v_d;
      result_q  <= result_d;
      wr_pend_q <= wr_pend_d;
      error_q   <= error_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    num_d     = num_q;
    i_d       = i_q;
    cap_d     = cap_q;
    c_d       = c_q;
    wr_c_d    = wr_c_q;
    w_d       = w_q;
    v_d       = v_q;
    result_d  = result_q;
    wr_pend_d = 1'b0;
    error_d   = error_q;
    item_addr = '0;
    rd_addr_a = '0;
    rd_addr_b = '0;
    wr_en     = 1'b0;
    wr_addr   = '0;
    wr_data   = '0;

    // Write stage: data for the capacity read last cycle has just returned.
    if (wr_pend_q) begin
      wr_en   = 1'b1;
      wr_addr = wr_c_q;
      wr_data = best;
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (start && !args_ok) begin
          error_d = 1'b1;
        end else if (start) begin
          num_d    = item_num;
          cap_d    = cap;
          error_d  = 1'b0;
          result_d = '0;
          c_d      = '0;
          state_d  = S_CLEAR;
        end
      end
      S_CLEAR: begin
        wr_en   = 1'b1;
        wr_addr = c_q;
        c_d     = c_q + CW'(1);
        if (c_q == cap_q) begin
          i_d     = '0;
          state_d = (num_q == '0) ? S_RESULT : S_FETCH;
        end
      end
      S_FETCH: begin
        item_addr = i_q[IW-1:0];
        state_d   = S_WAIT;
      end
      S_WAIT: begin
        w_d     = item_weight;
        v_d     = item_value;
        c_d     = cap_q;
        state_d = S_SCAN;
      end
      S_SCAN: begin
        rd_addr_a = c_q;
        rd_addr_b = fits ? (c_q - w_q[CW-1:0]) : '0;
        wr_pend_d = fits;
        wr_c_d    = c_q;
        if (c_q == '0) state_d = S_DRAIN;
        else           c_d     = c_q - CW'(1);
      end
      S_DRAIN: begin
        i_d     = i_nxt;
        state_d = (i_nxt < num_q) ? S_FETCH : S_RESULT;
      end
      S_RESULT: begin
        rd_addr_a = cap_q;
        state_d   = S_CAPTURE;
      end
      S_CAPTURE: begin
        result_d = rd_data_a;
        state_d  = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_knapsack_dp_seq.sv
// Self-checking bench for knapsack_dp_seq: item/cache RAM models, a plain DP reference and a write monitor.
module tb_knapsack_dp_seq;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [4:0]  item_num;
  logic [5:0]  cap;
  logic [3:0]  item_addr;
  logic [31:0] item_weight, item_value;
  logic [5:0]  rd_addr_a, rd_addr_b, wr_addr;
  logic [31:0] rd_data_a, rd_data_b, wr_data, result;
  logic        wr_en, busy, done, error;

  int n_cmp = 0;
  int n_fail = 0;

  logic [31:0] mem_w [16];
  logic [31:0] mem_v [16];
  logic [31:0] cache [64];

  typedef struct {
    logic [5:0]  a;
    logic [31:0] d;
  } wr_t;
  wr_t exp_q [$];

  knapsack_dp_seq dut (
    .clk(clk), .reset(reset), .start(start), .item_num(item_num), .cap(cap),
    .item_addr(item_addr), .item_weight(item_weight), .item_value(item_value),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done), .error(error), .result(result)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    item_weight <= mem_w[item_addr];
    item_value  <= mem_v[item_addr];
    rd_data_a   <= cache[rd_addr_a];
    rd_data_b   <= cache[rd_addr_b];
    if (wr_en) cache[wr_addr] <= wr_data;
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Every cache write the DUT issues must be the next one the reference expects.
  wr_t got_e;
  always @(negedge clk) begin
    if (!reset && wr_en) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_write: addr %0d data %h, no write expected (t=%0t)", wr_addr, wr_data, $time);
      end else begin
        got_e = exp_q.pop_front();
        check("wr_addr", {26'd0, wr_addr}, {26'd0, got_e.a});
        check("wr_data", wr_data, got_e.d);
      end
    end
  end

  // Reference: textbook 0/1 knapsack over a zeroed table, recording each cache write in order.
  function automatic logic [31:0] model(input int n, input int cp);
    logic [31:0] dp [64];
    logic [32:0] s;
    logic [31:0] sat, nv, w, v;
    for (int a = 0; a <= cp; a++) begin
      dp[a] = 32'd0;
      exp_q.push_back('{a: 6'(a), d: 32'd0});
    end
    for (int it = 0; it < n; it++) begin
      w = mem_w[it];
      v = mem_v[it];
      for (int c = cp; c >= 0; c--) begin
        if (w <= 32'(c)) begin
          s   = {1'b0, dp[c - int'(w)]} + {1'b0, v};
          sat = s[32] ? 32'hFFFF_FFFF : s[31:0];
          nv  = (dp[c] > sat) ? dp[c] : sat;
          dp[c] = nv;
          exp_q.push_back('{a: 6'(c), d: nv});
        end
      end
    end
    return dp[cp];
  endfunction

  task automatic check_zero(input string tag);
    check({tag, "_ctrl"}, {28'd0, busy, done, error, wr_en}, 32'd0);
    check({tag, "_addr"}, {10'd0, item_addr, rd_addr_a, rd_addr_b, wr_addr}, 32'd0);
    check({tag, "_wr_data"}, wr_data, 32'd0);
    check({tag, "_result"}, result, 32'd0);
  endtask

  task automatic run_case(input int n, input int cp, input bit pin, input logic [31:0] lit);
    logic [31:0] exp_res;
    int exp_lat, cnt;
    bit got;
    exp_res = model(n, cp);
    if (pin) check("model_pin", exp_res, lit);
    exp_lat = cp + 4 + n * (cp + 4);
    @(negedge clk);
    item_num = 5'(n);
    cap      = 6'(cp);
    start    = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    cnt = 0;
    got = 1'b0;
    while (cnt < exp_lat + 50 && !got) begin
      @(negedge clk);
      cnt++;
      if (cnt == 1) begin
        check("busy_on_accept", {31'd0, busy}, 32'd1);
        check("error_cleared", {31'd0, error}, 32'd0);
        check("result_cleared", result, 32'd0);
      end
      // A start with illegal args while busy must be ignored entirely.
      if (cnt == 3) begin
        start = 1'b1; item_num = 5'd31; cap = ~6'(cp);
      end
      if (cnt == 4) start = 1'b0;
      if (done) got = 1'b1;
    end
    start = 1'b0;
    if (!got) begin
      n_cmp++;
      n_fail++;
      $display("FAIL done_timeout: no done within %0d cycles, expected at %0d", cnt, exp_lat);
    end else begin
      check("latency", 32'(cnt), 32'(exp_lat));
      check("result", result, exp_res);
      check("busy_at_done", {31'd0, busy}, 32'd0);
      check("error_after_run", {31'd0, error}, 32'd0);
      @(negedge clk);
      check("done_pulse_len", {31'd0, done}, 32'd0);
      check("result_hold", result, exp_res);
      check("writes_all_seen", 32'(exp_q.size()), 32'd0);
    end
  endtask

  task automatic rand_items(input int cp);
    for (int k = 0; k < 16; k++) begin
      mem_w[k] = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, cp + 2));
      mem_v[k] = ($urandom_range(0, 7) == 0) ? 32'hFFFF_0000 + $urandom_range(0, 65535)
                                              : 32'($urandom_range(0, 1000));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, cp;
    reset = 1'b1; start = 1'b0; item_num = '0; cap = '0;
    for (int k = 0; k < 16; k++) begin mem_w[k] = 32'd0; mem_v[k] = 32'd0; end
    #1 check_zero("reset");
    repeat (3) @(posedge clk);
    @(negedge clk) reset = 1'b0;

    mem_w[0] = 1; mem_v[0] = 1;  mem_w[1] = 2; mem_v[1] = 6;
    mem_w[2] = 3; mem_v[2] = 10; mem_w[3] = 5; mem_v[3] = 16;
    run_case(4, 7, 1'b1, 32'd22);
    run_case(0, 5, 1'b1, 32'd0);

    for (int k = 0; k < 3; k++) begin mem_w[k] = 9; mem_v[k] = 32'($urandom_range(1, 500)); end
    run_case(3, 5, 1'b1, 32'd0);

    mem_w[0] = 1; mem_v[0] = 32'hFFFF_FFF0; mem_w[1] = 1; mem_v[1] = 32'h20;
    run_case(2, 2, 1'b1, 32'hFFFF_FFFF);

    @(negedge clk);
    item_num = 5'd17; cap = 6'd63; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    check("error_set", {31'd0, error}, 32'd1);
    check("error_busy", {31'd0, busy}, 32'd0);
    repeat (5) @(negedge clk);
    check("error_sticky", {31'd0, error}, 32'd1);
    check("error_idle", {30'd0, busy, done}, 32'd0);
    check("error_keeps_result", result, 32'hFFFF_FFFF);

    mem_w[0] = 32'h41; mem_v[0] = 100; mem_w[1] = 32'h8000_0002; mem_v[1] = 50;
    mem_w[2] = 3;      mem_v[2] = 7;
    run_case(3, 10, 1'b1, 32'd7);

    mem_w[0] = 0; mem_v[0] = 5; mem_w[1] = 0; mem_v[1] = 7;
    run_case(2, 0, 1'b1, 32'd12);

    rand_items(63);
    run_case(16, 63, 1'b0, 32'd0);
    for (int r = 0; r < 8; r++) begin
      n  = $urandom_range(1, 16);
      cp = $urandom_range(0, 63);
      rand_items(cp);
      run_case(n, cp, 1'b0, 32'd0);
    end

    cp = 20;
    rand_items(cp);
    void'(model(4, cp));
    @(negedge clk);
    item_num = 5'd4; cap = 6'(cp); start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (cp + 1 + 2 + 10) @(negedge clk);
    #2 reset = 1'b1;
    #1 check_zero("midrun_reset");
    exp_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    run_case(4, cp, 1'b0, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
